axi4_mmio_router: RTL and testbench

//  Parametrised 1-to-NUM_PORTS AXI4 address router between the core's MMIO master port and peripheral slaves.

---
 rtl/axi4_mmio_router.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi4_mmio_router.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mmio_router.sv
// 1-to-NUM_PORTS AXI4 MMIO address router with per-direction outstanding tracking,
// AW-ordered W steering and an internal DECERR slave for unmapped addresses.
//   state    | meaning
//   W_IDLE   | ERR write slave free
//   W_DRAIN  | discarding W beats of an unmapped write
//   W_RESP   | presenting DECERR B response
//   R_IDLE   | ERR read slave free
//   R_DATA   | returning DECERR R beats
module axi4_mmio_router #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64,
  parameter int ID_W            = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [NUM_PORTS*ADDR_W-1:0] BASE = {32'h6010_0000, 32'h6000_0000},
  parameter logic [NUM_PORTS*ADDR_W-1:0] MASK = {32'hFFF0_0000, 32'hFFF0_0000}
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          S_AXI_awvalid,
  output logic                          S_AXI_awready,
  input  logic [ID_W-1:0]               S_AXI_awid,
  input  logic [ADDR_W-1:0]             S_AXI_awaddr,
  input  logic [7:0]                    S_AXI_awlen,
  input  logic [2:0]                    S_AXI_awsize,
  input  logic [1:0]                    S_AXI_awburst,
  input  logic                          S_AXI_awlock,
  input  logic [3:0]                    S_AXI_awcache,
  input  logic [2:0]                    S_AXI_awprot,
  input  logic [3:0]                    S_AXI_awqos,
  input  logic                          S_AXI_wvalid,
  output logic                          S_AXI_wready,
  input  logic [DATA_W-1:0]             S_AXI_wdata,
  input  logic [DATA_W/8-1:0]           S_AXI_wstrb,
  input  logic                          S_AXI_wlast,
  output logic                          S_AXI_bvalid,
  input  logic                          S_AXI_bready,
  output logic [ID_W-1:0]               S_AXI_bid,
  output logic [1:0]                    S_AXI_bresp,
  input  logic                          S_AXI_arvalid,
  output logic                          S_AXI_arready,
  input  logic [ID_W-1:0]               S_AXI_arid,
  input  logic [ADDR_W-1:0]             S_AXI_araddr,
  input  logic [7:0]                    S_AXI_arlen,
  input  logic [2:0]                    S_AXI_arsize,
  input  logic [1:0]                    S_AXI_arburst,
  input  logic                          S_AXI_arlock,
  input  logic [3:0]                    S_AXI_arcache,
  input  logic [2:0]                    S_AXI_arprot,
  input  logic [3:0]                    S_AXI_arqos,
  output logic                          S_AXI_rvalid,
  input  logic                          S_AXI_rready,
  output logic [ID_W-1:0]               S_AXI_rid,
  output logic [DATA_W-1:0]             S_AXI_rdata,
  output logic [1:0]                    S_AXI_rresp,
  output logic                          S_AXI_rlast,
  output logic [NUM_PORTS-1:0]          M_AXI_awvalid,
  input  logic [NUM_PORTS-1:0]          M_AXI_awready,
  output logic [NUM_PORTS*ID_W-1:0]     M_AXI_awid,
  output logic [NUM_PORTS*ADDR_W-1:0]   M_AXI_awaddr,
  output logic [NUM_PORTS*8-1:0]        M_AXI_awlen,
  output logic [NUM_PORTS*3-1:0]        M_AXI_awsize,
  output logic [NUM_PORTS*2-1:0]        M_AXI_awburst,
  output logic [NUM_PORTS-1:0]          M_AXI_awlock,
  output logic [NUM_PORTS*4-1:0]        M_AXI_awcache,
  output logic [NUM_PORTS*3-1:0]        M_AXI_awprot,
  output logic [NUM_PORTS*4-1:0]        M_AXI_awqos,
  output logic [NUM_PORTS-1:0]          M_AXI_wvalid,
  input  logic [NUM_PORTS-1:0]          M_AXI_wready,
  output logic [NUM_PORTS*DATA_W-1:0]   M_AXI_wdata,
  output logic [NUM_PORTS*DATA_W/8-1:0] M_AXI_wstrb,
  output logic [NUM_PORTS-1:0]          M_AXI_wlast,
  input  logic [NUM_PORTS-1:0]          M_AXI_bvalid,
  output logic [NUM_PORTS-1:0]          M_AXI_bready,
  input  logic [NUM_PORTS*ID_W-1:0]     M_AXI_bid,
  input  logic [NUM_PORTS*2-1:0]        M_AXI_bresp,
  output logic [NUM_PORTS-1:0]          M_AXI_arvalid,
  input  logic [NUM_PORTS-1:0]          M_AXI_arready,
  output logic [NUM_PORTS*ID_W-1:0]     M_AXI_arid,
  output logic [NUM_PORTS*ADDR_W-1:0]   M_AXI_araddr,
  output logic [NUM_PORTS*8-1:0]        M_AXI_arlen,
  output logic [NUM_PORTS*3-1:0]        M_AXI_arsize,
  output logic [NUM_PORTS*2-1:0]        M_AXI_arburst,
  output logic [NUM_PORTS-1:0]          M_AXI_arlock,
  output logic [NUM_PORTS*4-1:0]        M_AXI_arcache,
  output logic [NUM_PORTS*3-1:0]        M_AXI_arprot,
  output logic [NUM_PORTS*4-1:0]        M_AXI_arqos,
  input  logic [NUM_PORTS-1:0]          M_AXI_rvalid,
  output logic [NUM_PORTS-1:0]          M_AXI_rready,
  input  logic [NUM_PORTS*ID_W-1:0]     M_AXI_rid,
  input  logic [NUM_PORTS*DATA_W-1:0]   M_AXI_rdata,
  input  logic [NUM_PORTS*2-1:0]        M_AXI_rresp,
  input  logic [NUM_PORTS-1:0]          M_AXI_rlast
);
  localparam int TW = $clog2(NUM_PORTS + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [TW-1:0] ERR  = TW'(NUM_PORTS);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} werr_e;
  typedef enum logic       {R_IDLE, R_DATA}          rerr_e;

  logic [TW-1:0]   aw_sel, ar_sel, wr_tgt_q, rd_tgt_q, w_head;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, fifo_cnt_q, fifo_cnt_d;
  logic [TW-1:0]   fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]   wptr_q, rptr_q;
  werr_e           werr_q;
  rerr_e           rerr_q;
  logic [ID_W-1:0] werr_id_q, rerr_id_q;
  logic [7:0]      rerr_beats_q;
  logic            aw_ok, ar_ok, aw_hs, ar_hs, w_hs, w_pop, b_hs, r_done;

  // Lowest index wins on overlapping windows; no hit selects ERR.
  function automatic logic [TW-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [TW-1:0] t;
    t = ERR;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if ((a & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) t = TW'(i);
    return t;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign aw_sel = decode(S_AXI_awaddr);
  assign ar_sel = decode(S_AXI_araddr);
  // Holding a single target while anything is outstanding keeps responses in order.
  assign aw_ok  = (wr_cnt_q < MAXC) && (wr_cnt_q == '0 || aw_sel == wr_tgt_q) &&
                  (aw_sel != ERR || werr_q == W_IDLE);
  assign ar_ok  = (rd_cnt_q < MAXC) && (rd_cnt_q == '0 || ar_sel == rd_tgt_q) &&
                  (ar_sel != ERR || rerr_q == R_IDLE);
  assign w_head = fifo_q[rptr_q];

  assign aw_hs  = S_AXI_awvalid & S_AXI_awready;
  assign ar_hs  = S_AXI_arvalid & S_AXI_arready;
  assign w_hs   = S_AXI_wvalid & S_AXI_wready;
  assign w_pop  = w_hs & S_AXI_wlast;
  assign b_hs   = S_AXI_bvalid & S_AXI_bready;
  assign r_done = S_AXI_rvalid & S_AXI_rready & S_AXI_rlast;

  assign wr_cnt_d   = wr_cnt_q + CW'(aw_hs) - CW'(b_hs);
  assign rd_cnt_d   = rd_cnt_q + CW'(ar_hs) - CW'(r_done);
  assign fifo_cnt_d = fifo_cnt_q + CW'(aw_hs) - CW'(w_pop);

  assign M_AXI_awid    = {NUM_PORTS{S_AXI_awid}};
  assign M_AXI_awaddr  = {NUM_PORTS{S_AXI_awaddr}};
  assign M_AXI_awlen   = {NUM_PORTS{S_AXI_awlen}};
  assign M_AXI_awsize  = {NUM_PORTS{S_AXI_awsize}};
  assign M_AXI_awburst = {NUM_PORTS{S_AXI_awburst}};
  assign M_AXI_awlock  = {NUM_PORTS{S_AXI_awlock}};
  assign M_AXI_awcache = {NUM_PORTS{S_AXI_awcache}};
  assign M_AXI_awprot  = {NUM_PORTS{S_AXI_awprot}};
  assign M_AXI_awqos   = {NUM_PORTS{S_AXI_awqos}};
  assign M_AXI_wdata   = {NUM_PORTS{S_AXI_wdata}};
  assign M_AXI_wstrb   = {NUM_PORTS{S_AXI_wstrb}};
  assign M_AXI_wlast   = {NUM_PORTS{S_AXI_wlast}};
  assign M_AXI_arid    = {NUM_PORTS{S_AXI_arid}};
  assign M_AXI_araddr  = {NUM_PORTS{S_AXI_araddr}};
  assign M_AXI_arlen   = {NUM_PORTS{S_AXI_arlen}};
  assign M_AXI_arsize  = {NUM_PORTS{S_AXI_arsize}};
  assign M_AXI_arburst = {NUM_PORTS{S_AXI_arburst}};
  assign M_AXI_arlock  = {NUM_PORTS{S_AXI_arlock}};
  assign M_AXI_arcache = {NUM_PORTS{S_AXI_arcache}};
  assign M_AXI_arprot  = {NUM_PORTS{S_AXI_arprot}};
  assign M_AXI_arqos   = {NUM_PORTS{S_AXI_arqos}};

  always_comb begin
    M_AXI_awvalid = '0;
    M_AXI_arvalid = '0;
    M_AXI_wvalid  = '0;
    M_AXI_bready  = '0;
    M_AXI_rready  = '0;
    S_AXI_awready = (aw_sel == ERR) & S_AXI_awvalid & aw_ok;
    S_AXI_arready = (ar_sel == ERR) & S_AXI_arvalid & ar_ok;
    S_AXI_wready  = (fifo_cnt_q != '0) && (w_head == ERR) && (werr_q == W_DRAIN);
    S_AXI_bvalid  = (wr_cnt_q != '0) && (wr_tgt_q == ERR) && (werr_q == W_RESP);
    S_AXI_bid     = werr_id_q;
    S_AXI_bresp   = 2'b11;
    S_AXI_rvalid  = (rd_cnt_q != '0) && (rd_tgt_q == ERR) && (rerr_q == R_DATA);
    S_AXI_rid     = rerr_id_q;
    S_AXI_rdata   = '0;
    S_AXI_rresp   = 2'b11;
    S_AXI_rlast   = (rerr_beats_q == 8'd0);
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (aw_sel == TW'(i)) begin
        M_AXI_awvalid[i] = S_AXI_awvalid & aw_ok;
        S_AXI_awready    = S_AXI_awvalid & aw_ok & M_AXI_awready[i];
      end
      if (ar_sel == TW'(i)) begin
        M_AXI_arvalid[i] = S_AXI_arvalid & ar_ok;
        S_AXI_arready    = S_AXI_arvalid & ar_ok & M_AXI_arready[i];
      end
      if (fifo_cnt_q != '0 && w_head == TW'(i)) begin
        M_AXI_wvalid[i] = S_AXI_wvalid;
        S_AXI_wready    = M_AXI_wready[i];
      end
      if (wr_cnt_q != '0 && wr_tgt_q == TW'(i)) begin
        M_AXI_bready[i] = S_AXI_bready;
        S_AXI_bvalid    = M_AXI_bvalid[i];
        S_AXI_bid       = M_AXI_bid[i*ID_W +: ID_W];
        S_AXI_bresp     = M_AXI_bresp[i*2 +: 2];
      end
      if (rd_cnt_q != '0 && rd_tgt_q == TW'(i)) begin
        M_AXI_rready[i] = S_AXI_rready;
        S_AXI_rvalid    = M_AXI_rvalid[i];
        S_AXI_rid       = M_AXI_rid[i*ID_W +: ID_W];
        S_AXI_rdata     = M_AXI_rdata[i*DATA_W +: DATA_W];
        S_AXI_rresp     = M_AXI_rresp[i*2 +: 2];
        S_AXI_rlast     = M_AXI_rlast[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      fifo_cnt_q   <= '0;
      wr_tgt_q     <= '0;
      rd_tgt_q     <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      werr_q       <= W_IDLE;
      rerr_q       <= R_IDLE;
      werr_id_q    <= '0;
      rerr_id_q    <= '0;
      rerr_beats_q <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (aw_hs) begin
        fifo_q[wptr_q] <= aw_sel;
        wptr_q         <= ptr_inc(wptr_q);
        wr_tgt_q       <= aw_sel;
      end
      if (w_pop) rptr_q <= ptr_inc(rptr_q);
      if (ar_hs) rd_tgt_q <= ar_sel;
      case (werr_q)
        W_IDLE:  if (aw_hs && aw_sel == ERR) begin
                   werr_q    <= W_DRAIN;
                   werr_id_q <= S_AXI_awid;
                 end
        W_DRAIN: if (w_pop && w_head == ERR) werr_q <= W_RESP;
        W_RESP:  if (b_hs) werr_q <= W_IDLE;
        default: werr_q <= W_IDLE;
      endcase
      case (rerr_q)
        R_IDLE: if (ar_hs && ar_sel == ERR) begin
                  rerr_q       <= R_DATA;
                  rerr_id_q    <= S_AXI_arid;
                  rerr_beats_q <= S_AXI_arlen;
                end
        R_DATA: if (S_AXI_rvalid && S_AXI_rready) begin
                  if (rerr_beats_q == 8'd0) rerr_q <= R_IDLE;
                  else rerr_beats_q <= rerr_beats_q - 8'd1;
                end
        default: rerr_q <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_mmio_router.sv
// Directed bench for axi4_mmio_router: mapped/unmapped writes and reads,
// outstanding limit, target-switch stall and mid-burst reset.
module tb_axi4_mmio_router;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic S_AXI_awvalid, S_AXI_awready, S_AXI_awlock;
  logic [IW-1:0] S_AXI_awid;
  logic [AW-1:0] S_AXI_awaddr;
  logic [7:0] S_AXI_awlen;
  logic [2:0] S_AXI_awsize, S_AXI_awprot;
  logic [1:0] S_AXI_awburst;
  logic [3:0] S_AXI_awcache, S_AXI_awqos;
  logic S_AXI_wvalid, S_AXI_wready, S_AXI_wlast;
  logic [DW-1:0] S_AXI_wdata;
  logic [DW/8-1:0] S_AXI_wstrb;
  logic S_AXI_bvalid, S_AXI_bready;
  logic [IW-1:0] S_AXI_bid;
  logic [1:0] S_AXI_bresp;
  logic S_AXI_arvalid, S_AXI_arready, S_AXI_arlock;
  logic [IW-1:0] S_AXI_arid;
  logic [AW-1:0] S_AXI_araddr;
  logic [7:0] S_AXI_arlen;
  logic [2:0] S_AXI_arsize, S_AXI_arprot;
  logic [1:0] S_AXI_arburst;
  logic [3:0] S_AXI_arcache, S_AXI_arqos;
  logic S_AXI_rvalid, S_AXI_rready, S_AXI_rlast;
  logic [IW-1:0] S_AXI_rid;
  logic [DW-1:0] S_AXI_rdata;
  logic [1:0] S_AXI_rresp;

  logic [NP-1:0] M_AXI_awvalid, M_AXI_awready, M_AXI_awlock;
  logic [NP*IW-1:0] M_AXI_awid;
  logic [NP*AW-1:0] M_AXI_awaddr;
  logic [NP*8-1:0] M_AXI_awlen;
  logic [NP*3-1:0] M_AXI_awsize, M_AXI_awprot;
  logic [NP*2-1:0] M_AXI_awburst;
  logic [NP*4-1:0] M_AXI_awcache, M_AXI_awqos;
  logic [NP-1:0] M_AXI_wvalid, M_AXI_wready, M_AXI_wlast;
  logic [NP*DW-1:0] M_AXI_wdata;
  logic [NP*DW/8-1:0] M_AXI_wstrb;
  logic [NP-1:0] M_AXI_bvalid, M_AXI_bready;
  logic [NP*IW-1:0] M_AXI_bid;
  logic [NP*2-1:0] M_AXI_bresp;
  logic [NP-1:0] M_AXI_arvalid, M_AXI_arready, M_AXI_arlock;
  logic [NP*IW-1:0] M_AXI_arid;
  logic [NP*AW-1:0] M_AXI_araddr;
  logic [NP*8-1:0] M_AXI_arlen;
  logic [NP*3-1:0] M_AXI_arsize, M_AXI_arprot;
  logic [NP*2-1:0] M_AXI_arburst;
  logic [NP*4-1:0] M_AXI_arcache, M_AXI_arqos;
  logic [NP-1:0] M_AXI_rvalid, M_AXI_rready, M_AXI_rlast;
  logic [NP*IW-1:0] M_AXI_rid;
  logic [NP*DW-1:0] M_AXI_rdata;
  logic [NP*2-1:0] M_AXI_rresp;

  axi4_mmio_router dut (
    .clk(clk), .reset_n(reset_n),
    .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready), .S_AXI_awid(S_AXI_awid),
    .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awlen(S_AXI_awlen), .S_AXI_awsize(S_AXI_awsize),
    .S_AXI_awburst(S_AXI_awburst), .S_AXI_awlock(S_AXI_awlock), .S_AXI_awcache(S_AXI_awcache),
    .S_AXI_awprot(S_AXI_awprot), .S_AXI_awqos(S_AXI_awqos),
    .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready), .S_AXI_wdata(S_AXI_wdata),
    .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wlast(S_AXI_wlast),
    .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready), .S_AXI_bid(S_AXI_bid),
    .S_AXI_bresp(S_AXI_bresp),
    .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready), .S_AXI_arid(S_AXI_arid),
    .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen), .S_AXI_arsize(S_AXI_arsize),
    .S_AXI_arburst(S_AXI_arburst), .S_AXI_arlock(S_AXI_arlock), .S_AXI_arcache(S_AXI_arcache),
    .S_AXI_arprot(S_AXI_arprot), .S_AXI_arqos(S_AXI_arqos),
    .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready), .S_AXI_rid(S_AXI_rid),
    .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp), .S_AXI_rlast(S_AXI_rlast),
    .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready), .M_AXI_awid(M_AXI_awid),
    .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awlen(M_AXI_awlen), .M_AXI_awsize(M_AXI_awsize),
    .M_AXI_awburst(M_AXI_awburst), .M_AXI_awlock(M_AXI_awlock), .M_AXI_awcache(M_AXI_awcache),
    .M_AXI_awprot(M_AXI_awprot), .M_AXI_awqos(M_AXI_awqos),
    .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready), .M_AXI_wdata(M_AXI_wdata),
    .M_AXI_wstrb(M_AXI_wstrb), .M_AXI_wlast(M_AXI_wlast),
    .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready), .M_AXI_bid(M_AXI_bid),
    .M_AXI_bresp(M_AXI_bresp),
    .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready), .M_AXI_arid(M_AXI_arid),
    .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen), .M_AXI_arsize(M_AXI_arsize),
    .M_AXI_arburst(M_AXI_arburst), .M_AXI_arlock(M_AXI_arlock), .M_AXI_arcache(M_AXI_arcache),
    .M_AXI_arprot(M_AXI_arprot), .M_AXI_arqos(M_AXI_arqos),
    .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready), .M_AXI_rid(M_AXI_rid),
    .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp), .M_AXI_rlast(M_AXI_rlast)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    S_AXI_awvalid = 0; S_AXI_awid = '0; S_AXI_awaddr = '0; S_AXI_awlen = '0;
    S_AXI_awsize = 3'd3; S_AXI_awburst = 2'b01; S_AXI_awlock = 0; S_AXI_awcache = '0;
    S_AXI_awprot = '0; S_AXI_awqos = '0;
    S_AXI_wvalid = 0; S_AXI_wdata = '0; S_AXI_wstrb = '1; S_AXI_wlast = 0; S_AXI_bready = 0;
    S_AXI_arvalid = 0; S_AXI_arid = '0; S_AXI_araddr = '0; S_AXI_arlen = '0;
    S_AXI_arsize = 3'd3; S_AXI_arburst = 2'b01; S_AXI_arlock = 0; S_AXI_arcache = '0;
    S_AXI_arprot = '0; S_AXI_arqos = '0; S_AXI_rready = 0;
    M_AXI_awready = 2'b11; M_AXI_wready = 2'b11; M_AXI_arready = 2'b11;
    M_AXI_bvalid = '0; M_AXI_bid = '0; M_AXI_bresp = '0;
    M_AXI_rvalid = '0; M_AXI_rid = '0; M_AXI_rdata = '0; M_AXI_rresp = '0; M_AXI_rlast = '0;

    tick(); tick();
    chk("rst_awready", S_AXI_awready, 0);
    chk("rst_wready", S_AXI_wready, 0);
    chk("rst_bvalid", S_AXI_bvalid, 0);
    chk("rst_rvalid", S_AXI_rvalid, 0);
    chk("rst_m_valids", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid}, 0);
    reset_n = 1'b1;
    tick();

    // 1: single-beat write to port 0
    S_AXI_awvalid = 1; S_AXI_awaddr = 32'h6000_0010; S_AXI_awid = 5'd5; S_AXI_awlen = 0;
    #1;
    chk("t1_m_awvalid", M_AXI_awvalid, 2'b01);
    chk("t1_awready", S_AXI_awready, 1);
    chk("t1_m_awaddr", M_AXI_awaddr[31:0], 32'h6000_0010);
    tick();
    S_AXI_awvalid = 0;
    chk("t1_wr_cnt1", dut.wr_cnt_q, 1);
    S_AXI_wvalid = 1; S_AXI_wdata = 64'hDEAD_BEEF_0123_4567; S_AXI_wlast = 1;
    #1;
    chk("t1_m_wvalid", M_AXI_wvalid, 2'b01);
    chk("t1_wready", S_AXI_wready, 1);
    chk("t1_m_wdata", M_AXI_wdata[63:0], 64'hDEAD_BEEF_0123_4567);
    tick();
    S_AXI_wvalid = 0; S_AXI_wlast = 0;
    M_AXI_bvalid = 2'b01; M_AXI_bid[4:0] = 5'd5; M_AXI_bresp[1:0] = 2'b00; S_AXI_bready = 1;
    #1;
    chk("t1_bvalid", S_AXI_bvalid, 1);
    chk("t1_bid", S_AXI_bid, 5);
    chk("t1_bresp", S_AXI_bresp, 0);
    chk("t1_m_bready", M_AXI_bready, 2'b01);
    tick();
    M_AXI_bvalid = 0; S_AXI_bready = 0;
    chk("t1_wr_cnt0", dut.wr_cnt_q, 0);

    // 2: four-beat read from port 1
    S_AXI_arvalid = 1; S_AXI_araddr = 32'h6010_0000; S_AXI_arid = 5'd9; S_AXI_arlen = 8'd3;
    #1;
    chk("t2_m_arvalid", M_AXI_arvalid, 2'b10);
    chk("t2_arready", S_AXI_arready, 1);
    chk("t2_m_arlen", M_AXI_arlen[15:8], 3);
    tick();
    S_AXI_arvalid = 0; S_AXI_rready = 1;
    for (int k = 0; k < 4; k++) begin
      M_AXI_rvalid = 2'b10; M_AXI_rid[9:5] = 5'd9; M_AXI_rdata[127:64] = 64'h1000 + 64'(k);
      M_AXI_rlast = (k == 3) ? 2'b10 : 2'b00;
      #1;
      chk("t2_rvalid", S_AXI_rvalid, 1);
      chk("t2_rid", S_AXI_rid, 9);
      chk("t2_rdata", S_AXI_rdata, 64'h1000 + 64'(k));
      chk("t2_rlast", S_AXI_rlast, (k == 3) ? 1 : 0);
      chk("t2_m_rready", M_AXI_rready, 2'b10);
      tick();
    end
    M_AXI_rvalid = 0; M_AXI_rlast = 0; S_AXI_rready = 0;
    chk("t2_rd_cnt0", dut.rd_cnt_q, 0);

    // 3: unmapped two-beat read -> DECERR
    S_AXI_arvalid = 1; S_AXI_araddr = 32'h7000_0000; S_AXI_arid = 5'd3; S_AXI_arlen = 8'd1;
    #1;
    chk("t3_m_arvalid", M_AXI_arvalid, 0);
    chk("t3_arready", S_AXI_arready, 1);
    tick();
    S_AXI_arvalid = 0;
    #1;
    chk("t3_rvalid0", S_AXI_rvalid, 1);
    chk("t3_rid", S_AXI_rid, 3);
    chk("t3_rdata", S_AXI_rdata, 0);
    chk("t3_rresp", S_AXI_rresp, 2'b11);
    chk("t3_rlast0", S_AXI_rlast, 0);
    S_AXI_rready = 1;
    tick();
    chk("t3_rvalid1", S_AXI_rvalid, 1);
    chk("t3_rlast1", S_AXI_rlast, 1);
    tick();
    S_AXI_rready = 0;
    chk("t3_rvalid_end", S_AXI_rvalid, 0);
    chk("t3_rd_cnt0", dut.rd_cnt_q, 0);

    // 4: outstanding limit of four reads
    S_AXI_araddr = 32'h6000_0100; S_AXI_arlen = 0;
    for (int k = 0; k < 4; k++) begin
      S_AXI_arvalid = 1; S_AXI_arid = 5'(k);
      #1;
      chk("t4_arready_k", S_AXI_arready, 1);
      tick();
    end
    S_AXI_arid = 5'd4;
    #1;
    chk("t4_arready_full", S_AXI_arready, 0);
    chk("t4_m_arvalid_full", M_AXI_arvalid, 0);
    tick();
    chk("t4_arready_hold", S_AXI_arready, 0);
    M_AXI_rvalid = 2'b01; M_AXI_rlast = 2'b01; S_AXI_rready = 1;
    tick();
    M_AXI_rvalid = 0;
    #1;
    chk("t4_arready_free", S_AXI_arready, 1);
    chk("t4_m_arvalid_free", M_AXI_arvalid, 2'b01);
    tick();
    S_AXI_arvalid = 0;
    M_AXI_rvalid = 2'b01;
    for (int k = 0; k < 4; k++) tick();
    M_AXI_rvalid = 0; M_AXI_rlast = 0; S_AXI_rready = 0;
    chk("t4_rd_cnt0", dut.rd_cnt_q, 0);

    // 5: target switch stalls until port 0 drains
    S_AXI_arvalid = 1; S_AXI_araddr = 32'h6000_0000; S_AXI_arid = 5'd1;
    tick();
    S_AXI_araddr = 32'h6010_0040; S_AXI_arid = 5'd2;
    #1;
    chk("t5_stall_arready", S_AXI_arready, 0);
    chk("t5_stall_m_arvalid", M_AXI_arvalid, 0);
    tick();
    M_AXI_rvalid = 2'b01; M_AXI_rlast = 2'b01; S_AXI_rready = 1;
    #1;
    chk("t5_p0_rvalid", S_AXI_rvalid, 1);
    chk("t5_stall2_arready", S_AXI_arready, 0);
    tick();
    M_AXI_rvalid = 0; M_AXI_rlast = 0;
    #1;
    chk("t5_go_m_arvalid", M_AXI_arvalid, 2'b10);
    chk("t5_go_arready", S_AXI_arready, 1);
    tick();
    S_AXI_arvalid = 0;
    M_AXI_rvalid = 2'b10; M_AXI_rlast = 2'b10;
    #1;
    chk("t5_p1_rvalid", S_AXI_rvalid, 1);
    tick();
    M_AXI_rvalid = 0; M_AXI_rlast = 0; S_AXI_rready = 0;
    chk("t5_rd_cnt0", dut.rd_cnt_q, 0);

    // 6: reset during beat 2 of a 4-beat write to port 1
    S_AXI_awvalid = 1; S_AXI_awaddr = 32'h6010_0000; S_AXI_awid = 5'd6; S_AXI_awlen = 8'd3;
    tick();
    S_AXI_awvalid = 0;
    S_AXI_wvalid = 1; S_AXI_wlast = 0;
    #1;
    chk("t6_m_wvalid", M_AXI_wvalid, 2'b10);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("t6_rst_wready", S_AXI_wready, 0);
    chk("t6_rst_m_wvalid", M_AXI_wvalid, 0);
    chk("t6_rst_wr_cnt", dut.wr_cnt_q, 0);
    chk("t6_rst_fifo", dut.fifo_cnt_q, 0);
    chk("t6_rst_bvalid", S_AXI_bvalid, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_post_wready", S_AXI_wready, 0);
    chk("t6_post_m_wvalid", M_AXI_wvalid, 0);
    S_AXI_wvalid = 0;

    // unmapped write -> DECERR B with echoed id
    S_AXI_awvalid = 1; S_AXI_awaddr = 32'h8000_0000; S_AXI_awid = 5'd7; S_AXI_awlen = 0;
    #1;
    chk("t7_m_awvalid", M_AXI_awvalid, 0);
    chk("t7_awready", S_AXI_awready, 1);
    tick();
    S_AXI_awvalid = 0; S_AXI_wvalid = 1; S_AXI_wlast = 1;
    #1;
    chk("t7_wready", S_AXI_wready, 1);
    chk("t7_m_wvalid", M_AXI_wvalid, 0);
    tick();
    S_AXI_wvalid = 0; S_AXI_wlast = 0;
    #1;
    chk("t7_bvalid", S_AXI_bvalid, 1);
    chk("t7_bid", S_AXI_bid, 7);
    chk("t7_bresp", S_AXI_bresp, 2'b11);
    S_AXI_bready = 1;
    tick();
    S_AXI_bready = 0;
    chk("t7_bvalid_end", S_AXI_bvalid, 0);
    chk("t7_wr_cnt0", dut.wr_cnt_q, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
